// File: rtl/myproject_mac_pkg.sv
// Shared types and the width-check helper for the MAC accumulator block.
package myproject_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } mac_state_e;

  // Narrowest accumulator that cannot overflow a full group of products.
  function automatic int acc_w_min(input int n_terms, input int in_w);
    return in_w + $clog2(n_terms) + 1;
  endfunction

endpackage

// File: rtl/myproject_acc_sat.sv
// Shift, saturate and optional ReLU of the accumulator (combinational).
// ReLU clamp is enabled by defining MYPROJECT_MAC_RELU_EN.
module myproject_acc_sat #(
  parameter int ACC_W = 24,
  parameter int SHIFT = 4,
  parameter int OUT_W = 16
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] res_o
);

  // One spare bit so the saturation bounds are representable for any ACC_W/OUT_W mix.
  localparam int W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [W-1:0] MAX_V = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = ~MAX_V;

  logic signed [W-1:0] acc_ext;
  logic signed [W-1:0] shifted;
  logic [OUT_W-1:0]    sat;

  assign acc_ext = W'(signed'(acc_i));
  assign shifted = acc_ext >>> SHIFT;

  always_comb begin
    if (shifted > MAX_V) begin
      sat = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      sat = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat = shifted[OUT_W-1:0];
    end
  end

`ifdef MYPROJECT_MAC_RELU_EN
  assign res_o = sat[OUT_W-1] ? '0 : sat;
`else
  assign res_o = sat;
`endif

endmodule

// File: rtl/myproject_mac_acc_13s.sv
// Streaming multiply-accumulate tail: sums N_TERMS products plus bias per group,
// then emits one shifted/saturated result. Optional ReLU: MYPROJECT_MAC_RELU_EN.
//   state     | meaning
//   ST_IDLE   | waiting for first beat of a group (bias sampled here)
//   ST_ACCUM  | accumulating remaining beats of the group
//   ST_OUTPUT | result held on m_tdata until m_tready
module myproject_mac_acc_13s
  import myproject_mac_pkg::*;
#(
  parameter int N_TERMS = 16,
  parameter int IN_W    = 13,
  parameter int ACC_W   = 24,
  parameter int SHIFT   = 4,
  parameter int OUT_W   = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [IN_W-1:0]  s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [ACC_W-1:0] bias,
  output logic [OUT_W-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             err_len
);

  localparam int CNT_W     = $clog2(N_TERMS + 1);
  localparam int ACC_W_MIN = acc_w_min(N_TERMS, IN_W);

  if (ACC_W < ACC_W_MIN) begin : g_acc_w_check
    $error("ACC_W is too narrow for N_TERMS and IN_W");
  end

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] m_tdata_q, m_tdata_d;
  logic             err_q, err_d;
  logic             rdy_q;

  logic             beat;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_beat;
  logic [OUT_W-1:0] res;

  assign s_tready = rdy_q && (state_q != ST_OUTPUT);
  assign m_tvalid = (state_q == ST_OUTPUT);
  assign m_tdata  = m_tdata_q;
  assign err_len  = err_q;

  assign beat      = s_tvalid && s_tready;
  assign prod_ext  = {{(ACC_W-IN_W){s_tdata[IN_W-1]}}, s_tdata};
  assign acc_sum   = ((state_q == ST_IDLE) ? bias : acc_q) + prod_ext;
  assign acc_d     = beat ? acc_sum : acc_q;
  assign cnt_inc   = (state_q == ST_IDLE) ? CNT_W'(1) : cnt_q + 1'b1;
  assign last_beat = (cnt_inc == CNT_W'(N_TERMS));

  // Result is computed from the post-beat sum so it registers on the final beat.
  myproject_acc_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_acc_sat (
    .acc_i (acc_sum),
    .res_o (res)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_tdata_d = m_tdata_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (beat) begin
          cnt_d = cnt_inc;
          if (s_tlast != last_beat) err_d = 1'b1;
          if (last_beat) begin
            m_tdata_d = res;
            state_d   = ST_OUTPUT;
          end else begin
            state_d   = ST_ACCUM;
          end
        end
      end
      ST_OUTPUT: begin
        if (m_tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      m_tdata_q <= '0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      m_tdata_q <= m_tdata_d;
      err_q     <= err_d;
      rdy_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_myproject_mac_acc_13s.sv
// Bench for myproject_mac_acc_13s: three parameterisations, directed table plus random groups.
`timescale 1ns/1ps
module tb_myproject_mac_acc_13s;

  localparam int NI    = 3;
  localparam int IN_W  = 13;
  localparam int ACC_W = 24;
  localparam int OUT_W = 16;
  localparam int INST_N  [NI] = '{4, 16, 16};
  localparam int INST_SH [NI] = '{4, 4, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n    [NI];
  logic [IN_W-1:0]  s_tdata  [NI];
  logic             s_tvalid [NI];
  logic             s_tready [NI];
  logic             s_tlast  [NI];
  logic [ACC_W-1:0] bias     [NI];
  logic [OUT_W-1:0] m_tdata  [NI];
  logic             m_tvalid [NI];
  logic             m_tready [NI];
  logic             err_len  [NI];

  myproject_mac_acc_13s #(.N_TERMS(4), .IN_W(IN_W), .ACC_W(ACC_W), .SHIFT(4), .OUT_W(OUT_W)) u_dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n[0]), .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]),
    .s_tready(s_tready[0]), .s_tlast(s_tlast[0]), .bias(bias[0]), .m_tdata(m_tdata[0]),
    .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .err_len(err_len[0]));
  myproject_mac_acc_13s #(.N_TERMS(16), .IN_W(IN_W), .ACC_W(ACC_W), .SHIFT(4), .OUT_W(OUT_W)) u_dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n[1]), .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]),
    .s_tready(s_tready[1]), .s_tlast(s_tlast[1]), .bias(bias[1]), .m_tdata(m_tdata[1]),
    .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .err_len(err_len[1]));
  myproject_mac_acc_13s #(.N_TERMS(16), .IN_W(IN_W), .ACC_W(ACC_W), .SHIFT(0), .OUT_W(OUT_W)) u_dut2 (
    .ap_clk(clk), .ap_rst_n(rst_n[2]), .s_tdata(s_tdata[2]), .s_tvalid(s_tvalid[2]),
    .s_tready(s_tready[2]), .s_tlast(s_tlast[2]), .bias(bias[2]), .m_tdata(m_tdata[2]),
    .m_tvalid(m_tvalid[2]), .m_tready(m_tready[2]), .err_len(err_len[2]));

  typedef struct {
    int     k;
    longint b;
    int     p [16];
    int     last_pos;
    int     stall;
    int     expv;
    string  name;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit exp_err [NI];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef MYPROJECT_MAC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: exact sum, wrap to ACC_W two's complement, floor divide, clamp.
  function automatic int model(input int k, input longint b, input int prods[$]);
    longint m = longint'(1) << ACC_W;
    longint d = longint'(1) << INST_SH[k];
    longint hi = (longint'(1) << (OUT_W-1)) - 1;
    longint lo = -(longint'(1) << (OUT_W-1));
    longint s = b;
    longint q;
    foreach (prods[i]) s += prods[i];
    s = ((s % m) + m) % m;
    if (s >= m/2) s -= m;
    q = s / d;
    if ((s % d) != 0 && s < 0) q -= 1;
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return relu(int'(q));
  endfunction

  function automatic longint sout(input int k);
    return longint'($signed(m_tdata[k]));
  endfunction

  task automatic run_group(input int k, input longint b, input int prods[$], input int last_pos,
                           input int gap, input int stall, input int expv, input string name);
    int n = INST_N[k];
    int g;
    m_tready[k] = (stall == 0);
    if (last_pos != n) exp_err[k] = 1'b1;
    for (int i = 0; i < n; i++) begin
      g = (gap > 0) ? $urandom_range(0, gap) : 0;
      s_tvalid[k] = 1'b0;
      bias[k] = ACC_W'($urandom);
      for (int j = 0; j < g; j++) @(negedge clk);
      s_tvalid[k] = 1'b1;
      s_tdata[k]  = IN_W'(prods[i]);
      s_tlast[k]  = (i + 1 == last_pos);
      bias[k]     = (i == 0) ? ACC_W'(b) : ACC_W'($urandom);
      check({name, "_s_tready"}, s_tready[k], 1);
      @(negedge clk);
      if (i < n - 1) check({name, "_early_valid"}, m_tvalid[k], 0);
    end
    s_tvalid[k] = 1'b0;
    s_tlast[k]  = 1'b0;
    check({name, "_m_tvalid"}, m_tvalid[k], 1);
    check({name, "_m_tdata"}, sout(k), expv);
    check({name, "_err_len"}, err_len[k], exp_err[k]);
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      check({name, "_hold_data"}, sout(k), expv);
      check({name, "_hold_valid"}, m_tvalid[k], 1);
      check({name, "_hold_s_tready"}, s_tready[k], 0);
    end
    m_tready[k] = 1'b1;
    @(negedge clk);
    check({name, "_post_valid"}, m_tvalid[k], 0);
    check({name, "_post_s_tready"}, s_tready[k], 1);
  endtask

  task automatic pulse_reset(input int k, input string name);
    rst_n[k] = 1'b0;
    #1;
    check({name, "_rst_s_tready"}, s_tready[k], 0);
    check({name, "_rst_m_tvalid"}, m_tvalid[k], 0);
    check({name, "_rst_m_tdata"}, sout(k), 0);
    check({name, "_rst_err_len"}, err_len[k], 0);
    @(negedge clk);
    rst_n[k] = 1'b1;
    exp_err[k] = 1'b0;
    #1;
    check({name, "_rel_s_tready"}, s_tready[k], 0);
    @(negedge clk);
    check({name, "_rel_s_tready_up"}, s_tready[k], 1);
    check({name, "_rel_m_tvalid"}, m_tvalid[k], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    int   q [$];
    int   k, n, lp;
    longint b;

    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tdata[i] = '0;
      bias[i] = '0; m_tready[i] = 1'b1; exp_err[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < NI; i++) begin
      check("reset_s_tready", s_tready[i], 0);
      check("reset_m_tvalid", m_tvalid[i], 0);
      check("reset_m_tdata", sout(i), 0);
      check("reset_err_len", err_len[i], 0);
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    #1;
    check("release_s_tready_low", s_tready[0], 0);
    @(negedge clk);
    for (int i = 0; i < NI; i++) check("release_s_tready_high", s_tready[i], 1);

    for (int i = 0; i < 10; i++) begin
      vecs[i].p = '{default: 0};
      vecs[i].b = 0;
      vecs[i].stall = 0;
      vecs[i].k = 0;
    end
    vecs[0].p[0:3] = '{100, -20, 7, 1};    vecs[0].expv = 5;      vecs[0].name = "basic_88";
    vecs[1].k = 1; vecs[1].p = '{default: 4095}; vecs[1].expv = 4095;  vecs[1].name = "max_sh4";
    vecs[2].k = 2; vecs[2].p = '{default: 4095}; vecs[2].expv = 32767; vecs[2].name = "max_sh0_sat";
    vecs[3].p[0:3] = '{-20, -20, -10, 2};  vecs[3].expv = -3;     vecs[3].name = "neg_48";
    vecs[4].p[0:3] = '{100, -20, 7, 1};    vecs[4].expv = 5;      vecs[4].stall = 5; vecs[4].name = "backpressure";
    vecs[5].k = 2; vecs[5].p = '{default: -4096}; vecs[5].expv = -32768; vecs[5].name = "min_sat";
    vecs[6].b = 8388607; vecs[6].p[0:3] = '{1, 0, 0, 0}; vecs[6].expv = -32768; vecs[6].name = "acc_wrap";
    vecs[7].p[0:3] = '{-1, 0, 0, 0};       vecs[7].expv = -1;     vecs[7].name = "floor_neg";
    vecs[8].b = 1000; vecs[8].p[0:3] = '{15, 0, 0, 1}; vecs[8].expv = 63; vecs[8].name = "bias_floor";
    vecs[9].k = 1; for (int j = 0; j < 16; j++) vecs[9].p[j] = j + 1;
    vecs[9].expv = 8; vecs[9].name = "ramp_136";

    for (int i = 0; i < 10; i++) begin
      q.delete();
      for (int j = 0; j < INST_N[vecs[i].k]; j++) q.push_back(vecs[i].p[j]);
      run_group(vecs[i].k, vecs[i].b, q, INST_N[vecs[i].k], 0, vecs[i].stall,
                relu(vecs[i].expv), vecs[i].name);
    end

    // Early tlast on beat 2 of 4: flag sets, grouping stays count-based, flag is sticky.
    q = '{10, 20, 30, 40};
    run_group(0, 0, q, 2, 0, 0, 6, "early_tlast");
    q = '{16, 16, 16, 16};
    run_group(0, 0, q, 4, 0, 0, 4, "after_err");
    check("err_sticky", err_len[0], 1);

    // Reset after 2 of 4 beats: partial group discarded.
    for (int i = 0; i < 2; i++) begin
      s_tvalid[0] = 1'b1; s_tdata[0] = IN_W'(500); s_tlast[0] = 1'b0; bias[0] = ACC_W'(77);
      @(negedge clk);
    end
    s_tvalid[0] = 1'b0;
    pulse_reset(0, "mid_group");
    q = '{16, 32, 48, 64};
    run_group(0, 0, q, 4, 0, 0, 10, "post_reset");

    // Reset while a result is pending: no output beat afterwards.
    m_tready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_tvalid[0] = 1'b1; s_tdata[0] = IN_W'(1000); s_tlast[0] = (i == 3); bias[0] = '0;
      @(negedge clk);
    end
    s_tvalid[0] = 1'b0; s_tlast[0] = 1'b0;
    check("pending_valid", m_tvalid[0], 1);
    check("pending_data", sout(0), relu(250));
    pulse_reset(0, "mid_output");
    m_tready[0] = 1'b1;
    @(negedge clk);
    check("mid_output_no_beat", m_tvalid[0], 0);

    // Random groups, including occasional length errors and bias extremes.
    for (int r = 0; r < 24; r++) begin
      k = r % NI;
      n = INST_N[k];
      q.delete();
      for (int j = 0; j < n; j++) q.push_back(int'($urandom_range(0, 8191)) - 4096);
      b = longint'($urandom_range(0, (1 << ACC_W) - 1));
      if (b >= (longint'(1) << (ACC_W-1))) b -= longint'(1) << ACC_W;
      if ($urandom_range(0, 1) == 0) b = b / 256;
      lp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n)) : n;
      run_group(k, b, q, lp, 2, int'($urandom_range(0, 3)), model(k, b, q), $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
